// File: rtl/nios2_oci_trace_monitor.sv
// Captures DCT trace words into a FIFO with a first-word fall-through read port.
// A small FSM gates capture and sequences the end-of-test drain.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset; waits for the test to be running
// RUN   | capturing a trace word on every dct_count change
// DRAIN | capture stopped; consumer empties the FIFO
// DONE  | FIFO empty and test ended; sticky until reset
module nios2_oci_trace_monitor #(
    parameter int DATA_W  = 30,
    parameter int COUNT_W = 4,
    parameter int DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DATA_W-1:0]             dct_buffer,
    input  logic [COUNT_W-1:0]            dct_count,
    input  logic                          test_ending,
    input  logic                          test_has_ended,
    input  logic                          rd_ready,
    output logic                          rd_valid,
    output logic [DATA_W+COUNT_W-1:0]     rd_data,
    output logic [$clog2(DEPTH):0]        fifo_level,
    output logic [15:0]                   drop_count,
    output logic [1:0]                    state,
    output logic                          monitor_done
);

    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = DATA_W + COUNT_W;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] DRAIN = 2'b10;
    localparam logic [1:0] DONE  = 2'b11;

    logic [1:0]         state_q;
    logic [1:0]         state_nxt;
    logic [COUNT_W-1:0] prev_count;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        level_q;
    logic [15:0]        drop_q;
    logic               done_q;
    logic [ENTRY_W-1:0] mem [DEPTH];

    logic capture;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign capture = (state_q == RUN) && (dct_count != prev_count);
    assign full    = (level_q == FULL_LVL);
    assign pop     = (level_q != '0) && rd_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (!test_ending && !test_has_ended) state_nxt = RUN;
            RUN:     if (test_ending || test_has_ended) state_nxt = DRAIN;
            DRAIN:   if ((level_q == '0) && test_has_ended) state_nxt = DONE;
            default: state_nxt = DONE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            prev_count <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            prev_count <= dct_count;
            done_q     <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            drop_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
        end
    end

    // Storage is left unreset; contents are meaningless while rd_valid is low.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {dct_count, dct_buffer};
    end

    assign rd_valid     = (level_q != '0);
    assign rd_data      = mem[rd_ptr];
    assign fifo_level   = level_q;
    assign drop_count   = drop_q;
    assign state        = state_q;
    assign monitor_done = done_q;

endmodule

// File: tb/tb_nios2_oci_trace_monitor.sv
// Scoreboard bench for nios2_oci_trace_monitor at DEPTH=4: expected entries are
// queued when captures are driven and checked by a monitor as the FIFO is read.
module tb_nios2_oci_trace_monitor;

    localparam int DATA_W  = 30;
    localparam int COUNT_W = 4;
    localparam int DEPTH   = 4;

    logic                      clk;
    logic                      reset_n;
    logic [DATA_W-1:0]         dct_buffer;
    logic [COUNT_W-1:0]        dct_count;
    logic                      test_ending;
    logic                      test_has_ended;
    logic                      rd_ready;
    logic                      rd_valid;
    logic [DATA_W+COUNT_W-1:0] rd_data;
    logic [2:0]                fifo_level;
    logic [15:0]               drop_count;
    logic [1:0]                state;
    logic                      monitor_done;

    logic [DATA_W+COUNT_W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] cnt;

    nios2_oci_trace_monitor #(
        .DATA_W(DATA_W), .COUNT_W(COUNT_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer),
        .dct_count(dct_count), .test_ending(test_ending),
        .test_has_ended(test_has_ended), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .fifo_level(fifo_level),
        .drop_count(drop_count), .state(state), .monitor_done(monitor_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (reset_n && rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_underflow: got %0h expected none", rd_data);
                end else begin
                    check("sb_rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
                end
            end
        end
    endtask

    // Called at posedge+1; the capture edge has passed on return.
    task automatic drive(input logic [3:0] c, input logic [29:0] b, input bit acc);
        dct_count  = c;
        dct_buffer = b;
        if (acc) exp_q.push_back({c, b});
        @(posedge clk); #1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        fork
            monitor_loop();
        join_none

        reset_n = 1'b0; dct_buffer = '0; dct_count = '0;
        test_ending = 1'b0; test_has_ended = 1'b0; rd_ready = 1'b0;
        tick(3);
        check("rst_state", 64'(state), 64'(0));
        check("rst_level", 64'(fifo_level), 64'(0));
        check("rst_valid", 64'(rd_valid), 64'(0));
        check("rst_drop", 64'(drop_count), 64'(0));
        check("rst_done", 64'(monitor_done), 64'(0));

        // Count change during the IDLE cycle is not captured.
        reset_n = 1'b1;
        dct_count = 4'd5;
        tick(1);
        check("idle_to_run", 64'(state), 64'(1));
        tick(1);
        check("idle_no_cap", 64'(fifo_level), 64'(0));

        // Basic capture and FWFT read.
        drive(4'd1, 30'h1, 1);
        drive(4'd2, 30'h2, 1);
        tick(1);
        check("basic_level2", 64'(fifo_level), 64'(2));
        check("basic_head", 64'(rd_data), 64'({4'd1, 30'h1}));
        rd_ready = 1'b1; tick(1); rd_ready = 1'b0;
        check("basic_level1", 64'(fifo_level), 64'(1));
        check("basic_head2", 64'(rd_data), 64'({4'd2, 30'h2}));
        tick(2);
        check("basic_hold", 64'(rd_data), 64'({4'd2, 30'h2}));
        rd_ready = 1'b1; tick(1);
        check("basic_empty", 64'(rd_valid), 64'(0));
        tick(2);
        check("underflow_lvl", 64'(fifo_level), 64'(0));
        rd_ready = 1'b0;

        // Overflow: 4 accepted, 2 dropped.
        for (int i = 3; i <= 8; i++) drive(4'(i), 30'h10 + 30'(i), i <= 6);
        check("ovf_level", 64'(fifo_level), 64'(4));
        check("ovf_drop", 64'(drop_count), 64'(2));

        // Full FIFO: simultaneous capture and pop.
        rd_ready = 1'b1;
        drive(4'd9, 30'h99, 1);
        rd_ready = 1'b0;
        check("fullpp_level", 64'(fifo_level), 64'(4));
        check("fullpp_drop", 64'(drop_count), 64'(2));
        rd_ready = 1'b1; tick(4); rd_ready = 1'b0;
        check("drain_level", 64'(fifo_level), 64'(0));

        // Build level=3, drop_count=5, then pulse reset.
        for (int i = 10; i <= 16; i++) drive(4'(i), 30'h200 + 30'(i), i <= 13);
        check("pre_rst_drop", 64'(drop_count), 64'(5));
        rd_ready = 1'b1; tick(1); rd_ready = 1'b0;
        check("pre_rst_level", 64'(fifo_level), 64'(3));
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_state", 64'(state), 64'(0));
        check("mid_rst_level", 64'(fifo_level), 64'(0));
        check("mid_rst_valid", 64'(rd_valid), 64'(0));
        check("mid_rst_drop", 64'(drop_count), 64'(0));
        check("mid_rst_done", 64'(monitor_done), 64'(0));
        tick(2);
        reset_n = 1'b1;
        tick(1);
        check("rerun_state", 64'(state), 64'(1));

        // End of test: capture on the test_ending edge, then drain to DONE.
        test_ending = 1'b1;
        drive(4'd1, 30'h44, 1);
        check("end_state", 64'(state), 64'(2));
        check("end_level", 64'(fifo_level), 64'(1));
        drive(4'd2, 30'h45, 0);
        drive(4'd3, 30'h46, 0);
        check("drain_nocap", 64'(fifo_level), 64'(1));
        test_has_ended = 1'b1;
        tick(1);
        check("drain_wait", 64'(state), 64'(2));
        rd_ready = 1'b1; tick(1); rd_ready = 1'b0;
        check("drain_pop", 64'(state), 64'(2));
        tick(1);
        check("done_state", 64'(state), 64'(3));
        check("done_flag", 64'(monitor_done), 64'(1));
        test_ending = 1'b0; test_has_ended = 1'b0;
        tick(3);
        check("done_sticky", 64'(state), 64'(3));

        // Saturating drop counter.
        reset_n = 1'b0; exp_q.delete();
        tick(2);
        reset_n = 1'b1;
        tick(1);
        cnt = dct_count;
        for (int i = 0; i < 4; i++) begin
            cnt = cnt + 4'd1;
            drive(cnt, 30'h300 + 30'(i), 1);
        end
        for (int i = 0; i < 65534; i++) begin
            cnt = cnt + 4'd1;
            drive(cnt, 30'h3FF, 0);
        end
        check("sat_fffe", 64'(drop_count), 64'(16'hFFFE));
        cnt = cnt + 4'd1;
        drive(cnt, 30'h3FF, 0);
        check("sat_ffff", 64'(drop_count), 64'(16'hFFFF));
        for (int i = 0; i < 5; i++) begin
            cnt = cnt + 4'd1;
            drive(cnt, 30'h3FF, 0);
        end
        check("sat_hold", 64'(drop_count), 64'(16'hFFFF));
        rd_ready = 1'b1; tick(4); rd_ready = 1'b0;
        check("sat_drain", 64'(fifo_level), 64'(0));
        check("sb_empty", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nios2_oci_trace_monitor.md
NIOS2_OCI_TRACE_MONITOR -- requirements
Module: nios2_oci_trace_monitor

Interface
REQ-001 Parameter DATA_W, default 30, width of the DCT trace word.
REQ-002 Parameter COUNT_W, default 4, width of the DCT count tag.
REQ-003 Parameter DEPTH, default 16, FIFO entries; power of two, >= 2.
REQ-004 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port dct_buffer  input  DATA_W  trace word from the OCI DCT buffer.
REQ-007 Port dct_count  input  COUNT_W  DCT frame counter; a change marks a new trace word.
REQ-008 Port test_ending  input  1  test is winding down; stop capturing.
REQ-009 Port test_has_ended  input  1  test is complete.
REQ-010 Port rd_ready  input  1  consumer accepts the head entry.
REQ-011 Port rd_valid  output  1  FIFO holds at least one entry.
REQ-012 Port rd_data  output  DATA_W+COUNT_W  head entry, {count, buffer}.
REQ-013 Port fifo_level  output  log2(DEPTH)+1  current entry count, 0..DEPTH.
REQ-014 Port drop_count  output  16  entries lost to a full FIFO; saturating.
REQ-015 Port state  output  2  FSM state encoding.
REQ-016 Port monitor_done  output  1  high in DONE only.

Function
REQ-017 FSM states: IDLE=00, RUN=01, DRAIN=10, DONE=11.
REQ-018 IDLE -> RUN when test_ending=0 and test_has_ended=0; otherwise remain in IDLE.
REQ-019 RUN -> DRAIN when test_ending=1 or test_has_ended=1.
REQ-020 DRAIN -> DONE when fifo_level=0 and test_has_ended=1.
REQ-021 DONE is sticky until reset.
REQ-022 prev_count register loads dct_count every cycle in every state.
REQ-023 A capture event occurs in a cycle with state=RUN and dct_count != prev_count.
REQ-024 Capture in the cycle test_ending rises while in RUN is still taken; no captures in IDLE, DRAIN, or DONE.
REQ-025 Each capture pushes {dct_count, dct_buffer} from the same cycle.
REQ-026 Capture with FIFO not full: write the entry; fifo_level increments next cycle.
REQ-027 Capture with FIFO full and no pop: drop the entry; drop_count +1, saturating at 16'hFFFF.
REQ-028 Capture with FIFO full and pop in the same cycle: accept both, no drop, level stays DEPTH.
REQ-029 Read is first-word fall-through.
REQ-030 rd_valid = (fifo_level != 0); rd_data = head entry.
REQ-031 Pop occurs on rd_valid & rd_ready.
REQ-032 rd_data is held stable while rd_valid=1 and rd_ready=0.
REQ-033 Empty FIFO with push: no same-cycle bypass; rd_valid rises the next cycle.
REQ-034 rd_ready while empty: ignored, no underflow.
REQ-035 Read and write pointers wrap modulo DEPTH.
REQ-036 Reads stay enabled in all states so the consumer can drain in DRAIN and DONE.
REQ-037 monitor_done is registered and equals (state==DONE).

Reset
REQ-038 reset_n=0 asynchronously forces: state=IDLE, both pointers=0, fifo_level=0, rd_valid=0, drop_count=0, monitor_done=0, prev_count=0.
REQ-039 Reset mid-operation discards all FIFO contents; rd_data is don't-care while rd_valid=0.
REQ-040 First capture after reset release requires the IDLE->RUN cycle; dct_count changes during IDLE are not captured.

Verification
REQ-041 Defaults; reset; dct_count 0->1->2 with buffers 0x1,0x2; rd_ready=0 -> level=2; rd_data={1,0x0000001} then {2,0x0000002} after a pop.
REQ-042 DEPTH=4; 6 captures with no reads -> level=4, drop_count=2; the 4 oldest entries read in order.
REQ-043 Full FIFO; capture and pop in the same cycle -> level=4, drop_count unchanged, new entry at the tail.
REQ-044 In RUN: test_ending=1 with a same-cycle count change -> entry captured, state=DRAIN; later count changes are ignored; after reads empty the FIFO and test_has_ended=1 -> state=DONE, monitor_done=1.
REQ-045 reset_n pulsed low with level=3 and drop_count=5 -> all outputs zero immediately; state=IDLE.
REQ-046 drop_count preloaded near 0xFFFF via a long overflow run -> holds at 0xFFFF without wrapping.
